// File: rtl/pulse_dec_pkg.sv
// Shared types and helpers for the pulse width decoder.
// Holds the FSM state encoding and the parameter legality check.
package pulse_dec_pkg;

    typedef enum logic [1:0] {
        Arm   = 2'd0,
        Idle  = 2'd1,
        Meas  = 2'd2,
        Stuck = 2'd3
    } dec_state_e;

    // Legal when 1 <= min_w <= max_w < 2**cw.
    function automatic bit widths_legal(input int unsigned cw, input int unsigned min_w,
                                         input int unsigned max_w);
        return (cw >= 1) && (cw < 32) && (min_w >= 1) && (min_w <= max_w)
            && (max_w < (32'd1 << cw));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures high pulses on din, strobing valid/glitch/err with the measured width.
// Define SYNC_EN to pass din through a 2-flop synchronizer (adds 2 cycles of latency).
module pulse_width_decoder
    import pulse_dec_pkg::*;
#(
    parameter int unsigned CW    = 8,
    parameter int unsigned MIN_W = 2,
    parameter int unsigned MAX_W = 200
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          din,
    output logic          pulse_valid,
    output logic [CW-1:0] pulse_width,
    output logic          pulse_glitch,
    output logic          pulse_err,
    output logic          busy
);

    if (!widths_legal(CW, MIN_W, MAX_W)) begin : g_param_check
        $error("pulse_width_decoder: illegal CW/MIN_W/MAX_W combination");
    end

    localparam logic [CW-1:0] MaxW = CW'(MAX_W);
    localparam logic [CW-1:0] MinW = CW'(MIN_W);

    logic din_s;

`ifdef SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (din),
        .q     (din_s)
    );
`else
    assign din_s = din;
`endif

    dec_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] width_q, width_d;
    logic          valid_q, valid_d;
    logic          glitch_q, glitch_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        valid_d  = 1'b0;
        glitch_d = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            // A line already high at reset must drop once before anything is measured.
            Arm: begin
                if (!din_s) begin
                    state_d = Idle;
                end
            end
            Idle: begin
                if (din_s) begin
                    state_d = Meas;
                    cnt_d   = CW'(1);
                end
            end
            Meas: begin
                if (din_s) begin
                    if (cnt_q == MaxW) begin
                        state_d = Stuck;
                        err_d   = 1'b1;
                        width_d = MaxW;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = Idle;
                    cnt_d   = '0;
                    if (cnt_q >= MinW) begin
                        valid_d = 1'b1;
                        width_d = cnt_q;
                    end else begin
                        glitch_d = 1'b1;
                    end
                end
            end
            Stuck: begin
                if (!din_s) begin
                    state_d = Idle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = Arm;
            end
        endcase

        busy_d = (state_d == Meas) || (state_d == Stuck);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= Arm;
            cnt_q    <= '0;
            width_q  <= '0;
            valid_q  <= 1'b0;
            glitch_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            glitch_q <= glitch_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign pulse_valid  = valid_q;
    assign pulse_width  = width_q;
    assign pulse_glitch = glitch_q;
    assign pulse_err    = err_q;
    assign busy         = busy_q;

endmodule
